useq_ctl: RTL
=============

Name: useq_ctl

Overview:
- Parametrised microcode sequencer; next generation of the 65C02 control sequencer.
- Drives the address of an external synchronous microcode ROM and passes the control word through to the datapath (ALU, register file, address logic).
- New over the previous generation:
  - configurable opcode, address, word and finisher widths;
  - conditional micro-branches;
  - micro-subroutine call/return stack;
  - edge-triggered NMI with priority over IRQ;
  - WAIT micro-op;
  - RDY stall.

Parameters:
- OPC_W, 8: opcode width; decode address is {0, opcode}.
- UA_W, 10: microcode address width; must be >= OPC_W+1.
- CW, 40: microcode word width; must be >= UA_W+FIN_W+5.
- FIN_W, 5: finisher index width.
- STACK_DEPTH, 2: micro-return stack entries (1..8).
- FIN_BASE, 10'h140: finisher area base; finisher address = FIN_BASE | finish.
- RST_VEC, 10'h160: reset entry.
- IRQ_VEC, 10'h168: IRQ entry.
- NMI_VEC, 10'h170: NMI entry.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- rdy, in, 1: 0 = freeze sequencer.
- opcode, in, OPC_W: data bus, sampled on DECODE.
- cond, in, 1: branch condition from datapath.
- irq, in, 1: level IRQ request.
- nmi, in, 1: NMI request (rising-edge sensitive).
- I, in, 1: interrupt-disable flag.
- rom_addr, out, UA_W: next ROM address (combinational).
- rom_data, in, CW: ROM word for the current cycle (1-cycle ROM latency).
- ctl, out, CW-3: rom_data[CW-4:0] passthrough to datapath.
- sync, out, 1: current word is DECODE (opcode fetch cycle).
- we, out, 1: registered write enable.
- ustack_err, out, 1: sticky micro-stack over/underflow.

Behaviour:
- Word fields:
  - seq = rom_data[CW-1:CW-3];
  - we_next = rom_data[CW-4];
  - tgt = rom_data[UA_W-1:0];
  - fin = rom_data[UA_W+FIN_W-1:UA_W];
  - bpol = rom_data[UA_W+FIN_W].
- upc register holds the address of the current rom_data; upc <= rom_addr every enabled cycle.
- seq decode, giving rom_addr:
  - 000 DECODE: priority nmi_pend > (irq & ~I) > opcode. NMI gives NMI_VEC and clears nmi_pend. IRQ gives IRQ_VEC. Otherwise {0, opcode}.
  - 001 NEXT: tgt.
  - 010 FINISH: FIN_BASE | finish.
  - 011 NEXT_SAVE: tgt; finish <= fin.
  - 100 BRANCH: (cond ^ bpol) ? tgt : upc+1. Wrap modulo 2^UA_W.
  - 101 CALL: push upc+1; rom_addr = tgt.
  - 110 RETURN: pop into rom_addr.
  - 111 WAIT: rom_addr = upc (hold) until nmi_pend or irq is seen, regardless of I. Then behaves as DECODE, so the interrupt is taken only if the DECODE priority allows; otherwise the opcode path is taken.
- sync = (seq==000) & reset & rdy.
- we <= we_next when rdy=1; holds its value when rdy=0.
- NMI edge detect:
  - nmi_q <= nmi every cycle, including while rdy=0;
  - nmi & ~nmi_q sets nmi_pend;
  - if a set and a clear coincide, set wins.
- Stack:
  - depth STACK_DEPTH, pointer sp in 0..STACK_DEPTH.
  - CALL when full: push dropped, ustack_err <= 1, jump still taken.
  - RETURN when empty: rom_addr = RST_VEC, ustack_err <= 1.
- rdy=0:
  - rom_addr = upc (re-reads the same word);
  - upc, sp, stack, finish, we, nmi_pend clears are all frozen;
  - sync forced 0.
- reset=0, sampled at clk:
  - rom_addr = RST_VEC combinationally while low;
  - upc <= RST_VEC, sp <= 0, finish <= 0, nmi_pend <= 0, nmi_q <= nmi, we <= 0, ustack_err <= 0;
  - sync = 0;
  - reset dominates rdy and all interrupts.
- Reset release:
  - the first cycle after reset returns high executes the RST_VEC word;
  - reset mid-instruction abandons the sequence and empties the stack.
- Latency:
  - opcode on DECODE reaches its microword at rom_data next cycle;
  - interrupt sampling happens only at DECODE/WAIT boundaries.

Test Plan:
- Reset low 3 cycles, then high with ROM[0x160]=DECODE and opcode=0xA9 -> rom_addr=0x160 during reset, we=0, ustack_err=0. First DECODE drives rom_addr=0x0A9; sync=1 that cycle.
- ROM[0x0A5]=NEXT_SAVE tgt=0x101 fin=3; ROM[0x101]=FINISH -> rom_addr sequence 0x101 then 0x143.
- BRANCH tgt=0x120 bpol=0 at upc=0x110 -> cond=1 gives 0x120; cond=0 gives 0x111. With bpol=1 the results invert.
- CALL tgt=0x130 at 0x105, then RETURN -> 0x130, then 0x106. Three nested CALLs with depth 2 -> ustack_err=1 and third return address lost. RETURN on empty stack -> 0x160.
- Interrupt priority:
  - irq=1, I=0, nmi pulse same cycle before DECODE -> rom_addr=0x170, then the next DECODE -> 0x168.
  - irq=1, I=1 -> opcode path.
  - WAIT word with I=1 and irq rising -> hold until irq, then opcode path.
- rdy=0 for 4 cycles mid-sequence -> rom_addr constant at upc, sync=0, we unchanged. An nmi edge during the stall is latched and taken at the next DECODE after rdy=1.

Source files
------------

// File: rtl/useq_ctl.sv
// useq_ctl: parametrised microcode sequencer.
// Computes the next microcode ROM address from the sequencing field of the
// current word and passes the remaining control bits through to the datapath.
// It also provides a small micro-return stack, NMI edge capture, a WAIT hold
// and an RDY freeze.
module useq_ctl #(
  parameter int              OPC_W       = 8,
  parameter int              UA_W        = 10,
  parameter int              CW          = 40,
  parameter int              FIN_W       = 5,
  parameter int              STACK_DEPTH = 2,
  parameter logic [UA_W-1:0] FIN_BASE    = 10'h140,
  parameter logic [UA_W-1:0] RST_VEC     = 10'h160,
  parameter logic [UA_W-1:0] IRQ_VEC     = 10'h168,
  parameter logic [UA_W-1:0] NMI_VEC     = 10'h170
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdy,
  input  logic [OPC_W-1:0] opcode,
  input  logic             cond,
  input  logic             irq,
  input  logic             nmi,
  input  logic             I,
  output logic [UA_W-1:0]  rom_addr,
  input  logic [CW-1:0]    rom_data,
  output logic [CW-4:0]    ctl,
  output logic             sync,
  output logic             we,
  output logic             ustack_err
);

  // The stack pointer counts 0..STACK_DEPTH. The storage array is sized to the
  // full pointer range, so any pointer value is a legal index.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int STK_N = 1 << SP_W;

  typedef enum logic [2:0] {
    SEQ_DECODE    = 3'b000,
    SEQ_NEXT      = 3'b001,
    SEQ_FINISH    = 3'b010,
    SEQ_NEXT_SAVE = 3'b011,
    SEQ_BRANCH    = 3'b100,
    SEQ_CALL      = 3'b101,
    SEQ_RETURN    = 3'b110,
    SEQ_WAIT      = 3'b111
  } seq_e;

  // Microword fields.
  seq_e             seq;
  logic             we_next;
  logic [UA_W-1:0]  tgt;
  logic [FIN_W-1:0] fin;
  logic             bpol;

  assign seq     = seq_e'(rom_data[CW-1:CW-3]);
  assign we_next = rom_data[CW-4];
  assign tgt     = rom_data[UA_W-1:0];
  assign fin     = rom_data[UA_W+FIN_W-1:UA_W];
  assign bpol    = rom_data[UA_W+FIN_W];

  // Sequencer state.
  logic [UA_W-1:0]  upc_q;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [FIN_W-1:0] finish_q, finish_d;
  logic             nmi_q;
  logic             nmi_pend_q, nmi_pend_d;
  logic             we_q;
  logic             ustack_err_q, ustack_err_d;
  logic [UA_W-1:0]  stack_q [STK_N];

  logic [UA_W-1:0]  upc_inc;
  logic [UA_W-1:0]  dec_addr;
  logic             stack_full;
  logic             stack_empty;
  logic             push_en;
  logic             nmi_take;

  // upc+1 wraps naturally at the top of the address space.
  assign upc_inc     = upc_q + UA_W'(1);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // Instruction-boundary target: a pending NMI beats an unmasked IRQ, which
  // beats the opcode on the data bus.
  assign dec_addr = nmi_pend_q     ? NMI_VEC :
                    (irq & ~I)     ? IRQ_VEC :
                    UA_W'(opcode);

  // A new NMI edge always sets the pending flag, even if it is being taken
  // in the same cycle.
  assign nmi_pend_d = (nmi_pend_q & ~nmi_take) | (nmi & ~nmi_q);

  // Next-address selection and stack/finisher next-state.
  always_comb begin
    rom_addr     = upc_q;
    sp_d         = sp_q;
    finish_d     = finish_q;
    ustack_err_d = ustack_err_q;
    push_en      = 1'b0;
    nmi_take     = 1'b0;
    if (!reset) begin
      rom_addr = RST_VEC;
    end else if (rdy) begin
      case (seq)
        SEQ_DECODE: begin
          rom_addr = dec_addr;
          nmi_take = nmi_pend_q;
        end
        SEQ_NEXT: begin
          rom_addr = tgt;
        end
        SEQ_FINISH: begin
          rom_addr = FIN_BASE | UA_W'(finish_q);
        end
        SEQ_NEXT_SAVE: begin
          rom_addr = tgt;
          finish_d = fin;
        end
        SEQ_BRANCH: begin
          rom_addr = (cond ^ bpol) ? tgt : upc_inc;
        end
        SEQ_CALL: begin
          // The jump is taken even when the return address cannot be saved.
          rom_addr = tgt;
          if (stack_full) begin
            ustack_err_d = 1'b1;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
          end
        end
        SEQ_RETURN: begin
          if (stack_empty) begin
            rom_addr     = RST_VEC;
            ustack_err_d = 1'b1;
          end else begin
            rom_addr = stack_q[sp_q - SP_W'(1)];
            sp_d     = sp_q - SP_W'(1);
          end
        end
        SEQ_WAIT: begin
          // Any request wakes the sequencer; the mask only matters at the
          // decode that follows.
          if (nmi_pend_q | irq) begin
            rom_addr = dec_addr;
            nmi_take = nmi_pend_q;
          end
        end
      endcase
    end
  end

  // Control registers: NMI sampling never stalls; everything else advances only when rdy.
  always_ff @(posedge clk) begin
    nmi_q <= nmi;
    if (!reset) begin
      upc_q        <= RST_VEC;
      sp_q         <= '0;
      finish_q     <= '0;
      nmi_pend_q   <= 1'b0;
      we_q         <= 1'b0;
      ustack_err_q <= 1'b0;
    end else begin
      nmi_pend_q <= nmi_pend_d;
      if (rdy) begin
        upc_q        <= rom_addr;
        sp_q         <= sp_d;
        finish_q     <= finish_d;
        we_q         <= we_next;
        ustack_err_q <= ustack_err_d;
      end
    end
  end

  // Return-address storage; contents are meaningless below sp so no reset is needed.
  always_ff @(posedge clk) begin
    if (reset && rdy && push_en) begin
      stack_q[sp_q] <= upc_inc;
    end
  end

  assign ctl        = rom_data[CW-4:0];
  assign sync       = (seq == SEQ_DECODE) & reset & rdy;
  assign we         = we_q;
  assign ustack_err = ustack_err_q;

endmodule
